// File: rtl/lif_neuron_array.sv
// rtl/lif_neuron_array.sv - array of leaky integrate-and-fire neurons with shared threshold and spike counter
module lif_neuron_array #(
    parameter int N_CH       = 4,
    parameter int W          = 8,
    parameter int REFRAC     = 3,
    parameter int LEAK_SHIFT = 1,
    parameter int SPK_W      = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                step,
    input  logic                leak_en,
    input  logic [W-1:0]        thresh,
    input  logic [N_CH*W-1:0]   I_syn,
    output logic [N_CH*W-1:0]   V_mem,
    output logic [N_CH-1:0]     spike,
    output logic [N_CH-1:0]     refractory,
    output logic [SPK_W-1:0]    spike_total
);

    localparam int RC_W = $clog2(REFRAC + 1);

    typedef enum logic {
        ACTIVE     = 1'b0,
        REFRACTORY = 1'b1
    } state_t;

    state_t          state [N_CH];
    logic [RC_W-1:0] rc    [N_CH];
    logic [W-1:0]    v     [N_CH];

    logic [W-1:0]    leak  [N_CH];
    logic [W:0]      sum   [N_CH];
    logic [W-1:0]    sat   [N_CH];
    logic [N_CH-1:0] fire;
    logic [SPK_W-1:0] fire_cnt;

    // v - leak never underflows, so only the top carry needs saturating
    always_comb begin
        fire_cnt = '0;
        fire     = '0;
        for (int c = 0; c < N_CH; c++) begin
            leak[c] = leak_en ? (v[c] >> LEAK_SHIFT) : '0;
            sum[c]  = {1'b0, v[c]} - {1'b0, leak[c]} + {1'b0, I_syn[c*W +: W]};
            sat[c]  = sum[c][W] ? {W{1'b1}} : sum[c][W-1:0];
            fire[c] = step && (state[c] == ACTIVE) && (thresh != '0) && (sat[c] >= thresh);
            fire_cnt = fire_cnt + SPK_W'(fire[c]);
        end
    end

    always_comb begin
        V_mem      = '0;
        refractory = '0;
        for (int c = 0; c < N_CH; c++) begin
            V_mem[c*W +: W] = v[c];
            refractory[c]   = (state[c] == REFRACTORY);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            spike       <= '0;
            spike_total <= '0;
            for (int c = 0; c < N_CH; c++) begin
                state[c] <= ACTIVE;
                rc[c]    <= '0;
                v[c]     <= '0;
            end
        end else begin
            spike       <= fire;
            spike_total <= spike_total + fire_cnt;
            for (int c = 0; c < N_CH; c++) begin
                if (step) begin
                    case (state[c])
                        ACTIVE: begin
                            if (fire[c]) begin
                                v[c]     <= '0;
                                rc[c]    <= RC_W'(REFRAC);
                                state[c] <= REFRACTORY;
                            end else begin
                                v[c] <= sat[c];
                            end
                        end
                        REFRACTORY: begin
                            v[c]  <= '0;
                            rc[c] <= rc[c] - RC_W'(1);
                            if (rc[c] == RC_W'(1)) begin
                                state[c] <= ACTIVE;
                            end
                        end
                        default: state[c] <= ACTIVE;
                    endcase
                end
            end
        end
    end

endmodule

// File: tb/tb_lif_neuron_array.sv
// tb/tb_lif_neuron_array.sv - directed vector bench for lif_neuron_array
module tb_lif_neuron_array;

    logic        clk = 1'b0;
    logic        reset;
    logic        step;
    logic        leak_en;
    logic [7:0]  thresh;
    logic [31:0] I_syn;
    logic [31:0] V_mem;
    logic [3:0]  spike;
    logic [3:0]  refractory;
    logic [15:0] spike_total;
    logic [31:0] w_V_mem;
    logic [3:0]  w_spike;
    logic [3:0]  w_refractory;
    logic [2:0]  w_spike_total;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    lif_neuron_array #(.N_CH(4), .W(8), .REFRAC(3), .LEAK_SHIFT(1), .SPK_W(16)) dut (
        .clk(clk), .reset(reset), .step(step), .leak_en(leak_en), .thresh(thresh),
        .I_syn(I_syn), .V_mem(V_mem), .spike(spike), .refractory(refractory),
        .spike_total(spike_total)
    );

    lif_neuron_array #(.N_CH(4), .W(8), .REFRAC(3), .LEAK_SHIFT(1), .SPK_W(3)) dut_w (
        .clk(clk), .reset(reset), .step(step), .leak_en(leak_en), .thresh(thresh),
        .I_syn(I_syn), .V_mem(w_V_mem), .spike(w_spike), .refractory(w_refractory),
        .spike_total(w_spike_total)
    );

    typedef struct {
        logic        rst;
        logic        stp;
        logic        len;
        logic [7:0]  thr;
        logic [31:0] isyn;
        logic [31:0] v;
        logic [3:0]  spk;
        logic [3:0]  rf;
        logic [15:0] tot;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(logic rst, logic stp, logic len, logic [7:0] thr,
                                logic [31:0] isyn, logic [31:0] v, logic [3:0] spk,
                                logic [3:0] rf, logic [15:0] tot);
        vec_t r;
        r.rst = rst; r.stp = stp; r.len = len; r.thr = thr; r.isyn = isyn;
        r.v = v; r.spk = spk; r.rf = rf; r.tot = tot;
        return r;
    endfunction

    task automatic check(input int id, input string what, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL vec%0d %s: got %h expected %h", id, what, act, exp);
        end
    endtask

    task automatic apply(input vec_t t, input int id);
        logic [2:0] tot3;
        @(negedge clk);
        reset = t.rst; step = t.stp; leak_en = t.len; thresh = t.thr; I_syn = t.isyn;
        @(posedge clk);
        #1;
        tot3 = t.tot[2:0];
        check(id, "V_mem", V_mem, t.v);
        check(id, "spike", {28'd0, spike}, {28'd0, t.spk});
        check(id, "refractory", {28'd0, refractory}, {28'd0, t.rf});
        check(id, "spike_total", {16'd0, spike_total}, {16'd0, t.tot});
        check(id, "spike_total_w3", {29'd0, w_spike_total}, {29'd0, tot3});
    endtask

    initial begin
        reset = 1'b1; step = 1'b0; leak_en = 1'b0; thresh = 8'd0; I_syn = 32'd0;

        // reset with step high and junk inputs
        tbl.push_back(mk(1, 1, 1, 8'd5, 32'hABABABAB, 32'd0, 4'h0, 4'h0, 16'd0));
        // leak convergence on ch0
        tbl.push_back(mk(0, 1, 1, 8'd0, 32'd40, 32'd40, 4'h0, 4'h0, 16'd0));
        tbl.push_back(mk(0, 1, 1, 8'd0, 32'd40, 32'd60, 4'h0, 4'h0, 16'd0));
        tbl.push_back(mk(0, 1, 1, 8'd0, 32'd40, 32'd70, 4'h0, 4'h0, 16'd0));
        tbl.push_back(mk(0, 1, 1, 8'd0, 32'd40, 32'd75, 4'h0, 4'h0, 16'd0));
        tbl.push_back(mk(0, 1, 1, 8'd0, 32'd40, 32'd78, 4'h0, 4'h0, 16'd0));
        tbl.push_back(mk(0, 1, 1, 8'd0, 32'd40, 32'd79, 4'h0, 4'h0, 16'd0));
        tbl.push_back(mk(0, 1, 1, 8'd0, 32'd40, 32'd80, 4'h0, 4'h0, 16'd0));
        tbl.push_back(mk(0, 1, 1, 8'd0, 32'd40, 32'd80, 4'h0, 4'h0, 16'd0));
        tbl.push_back(mk(0, 0, 1, 8'd0, 32'd40, 32'd80, 4'h0, 4'h0, 16'd0));
        // fire and refractory on ch0
        tbl.push_back(mk(1, 0, 0, 8'd0, 32'd0, 32'd0, 4'h0, 4'h0, 16'd0));
        tbl.push_back(mk(0, 1, 0, 8'd100, 32'd30, 32'd30, 4'h0, 4'h0, 16'd0));
        tbl.push_back(mk(0, 1, 0, 8'd100, 32'd30, 32'd60, 4'h0, 4'h0, 16'd0));
        tbl.push_back(mk(0, 1, 0, 8'd100, 32'd30, 32'd90, 4'h0, 4'h0, 16'd0));
        tbl.push_back(mk(0, 1, 0, 8'd100, 32'd30, 32'd0, 4'h1, 4'h1, 16'd1));
        tbl.push_back(mk(0, 1, 0, 8'd100, 32'd30, 32'd0, 4'h0, 4'h1, 16'd1));
        tbl.push_back(mk(0, 1, 0, 8'd100, 32'd30, 32'd0, 4'h0, 4'h1, 16'd1));
        tbl.push_back(mk(0, 1, 0, 8'd100, 32'd30, 32'd0, 4'h0, 4'h0, 16'd1));
        tbl.push_back(mk(0, 1, 0, 8'd100, 32'd30, 32'd30, 4'h0, 4'h0, 16'd1));
        // saturation on ch0, ch1 integrates independently
        tbl.push_back(mk(1, 0, 0, 8'd0, 32'd0, 32'd0, 4'h0, 4'h0, 16'd0));
        tbl.push_back(mk(0, 1, 0, 8'd0, 32'h000001C8, 32'h000001C8, 4'h0, 4'h0, 16'd0));
        tbl.push_back(mk(0, 1, 0, 8'd0, 32'h000001C8, 32'h000002FF, 4'h0, 4'h0, 16'd0));
        tbl.push_back(mk(0, 1, 0, 8'd0, 32'h000001C8, 32'h000003FF, 4'h0, 4'h0, 16'd0));
        // threshold boundary: equal fires, one below does not
        tbl.push_back(mk(1, 0, 0, 8'd0, 32'd0, 32'd0, 4'h0, 4'h0, 16'd0));
        tbl.push_back(mk(0, 1, 0, 8'd50, 32'h00003132, 32'h00003100, 4'h1, 4'h1, 16'd1));
        tbl.push_back(mk(0, 1, 0, 8'd50, 32'h00003132, 32'h00000000, 4'h2, 4'h3, 16'd2));

        for (int i = 0; i < tbl.size(); i++) begin
            apply(tbl[i], i);
        end

        // all channels fire together; 3-bit counter wraps on the second volley
        apply(mk(1, 0, 0, 8'd0, 32'd0, 32'd0, 4'h0, 4'h0, 16'd0), 100);
        apply(mk(0, 1, 0, 8'd10, 32'hFFFFFFFF, 32'd0, 4'hF, 4'hF, 16'd4), 101);
        apply(mk(0, 1, 0, 8'd10, 32'hFFFFFFFF, 32'd0, 4'h0, 4'hF, 16'd4), 102);
        apply(mk(0, 1, 0, 8'd10, 32'hFFFFFFFF, 32'd0, 4'h0, 4'hF, 16'd4), 103);
        apply(mk(0, 1, 0, 8'd10, 32'hFFFFFFFF, 32'd0, 4'h0, 4'h0, 16'd4), 104);
        apply(mk(0, 1, 0, 8'd10, 32'hFFFFFFFF, 32'd0, 4'hF, 4'hF, 16'd8), 105);

        // reset while ch0 is mid-refractory, then integrate and hold
        apply(mk(1, 0, 0, 8'd0, 32'd0, 32'd0, 4'h0, 4'h0, 16'd0), 200);
        apply(mk(0, 1, 0, 8'd30, 32'd30, 32'd0, 4'h1, 4'h1, 16'd1), 201);
        apply(mk(0, 1, 0, 8'd30, 32'd30, 32'd0, 4'h0, 4'h1, 16'd1), 202);
        apply(mk(1, 1, 0, 8'd30, 32'hFFFFFFFF, 32'd0, 4'h0, 4'h0, 16'd0), 203);
        apply(mk(0, 1, 0, 8'd100, 32'd30, 32'd30, 4'h0, 4'h0, 16'd0), 204);
        for (int k = 0; k < 10; k++) begin
            apply(mk(0, 0, k[0], 8'($urandom_range(1, 255)), $urandom, 32'd30, 4'h0, 4'h0, 16'd0), 300 + k);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
